// File: rtl/excp_pkg.sv
// Shared types and exception codes for the exception/ertn commit controller.
package excp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    RET   = 2'd2,
    REDIR = 2'd3
  } excp_state_e;

  localparam logic [7:0] EC_INT  = 8'h00;
  localparam logic [7:0] EC_SYS  = 8'h0B;
  localparam logic [7:0] EC_BRK  = 8'h0C;
  localparam logic [7:0] EC_INE  = 8'h0D;
  localparam logic [7:0] EC_ALE  = 8'h09;
  localparam logic [7:0] EC_ADEF = 8'h08;

endpackage

// File: rtl/excp_prio.sv
// Combinational writeback event arbiter: interrupt > exception > ertn.
// Interrupts override the exception fields; nothing is taken without wb_valid.
module excp_prio
  import excp_pkg::*;
#(
  parameter logic [7:0] ECODE_INT = EC_INT
) (
  input  logic        wb_valid,
  input  logic        has_int,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [7:0]  wb_ecode,
  input  logic        wb_esubcode,
  input  logic [31:0] wb_vaddr,
  output logic        take_trap,
  output logic        take_ret,
  output logic [7:0]  sel_ecode,
  output logic        sel_esubcode,
  output logic [31:0] sel_vaddr
);

  always_comb begin
    take_trap    = wb_valid & (has_int | wb_ex);
    take_ret     = wb_valid & ~has_int & ~wb_ex & wb_ertn;
    sel_ecode    = wb_ecode;
    sel_esubcode = wb_esubcode;
    sel_vaddr    = wb_vaddr;
    if (has_int) begin
      sel_ecode    = ECODE_INT;
      sel_esubcode = 1'b0;
      sel_vaddr    = 32'h0;
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/ertn commit FSM: one-cycle CSR commit pulse, then fetch redirect handshake.
// Stalled redirects are counted; a sticky error flags a redirect that exceeds the timeout.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter logic [7:0] ECODE_INT     = EC_INT,
  parameter logic [7:0] REDIR_TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        wb_ex,
  input  logic [7:0]  wb_ecode,
  input  logic        wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        wb_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entryPC,
  input  logic [31:0] new_pc,
  output logic        ex_en,
  output logic [7:0]  ecode,
  output logic        esubcode,
  output logic [31:0] pc,
  output logic [31:0] vaddr,
  output logic        ertn_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        redirect_stall_err
);

  excp_state_e state_q;
  logic        wb_ready_q, ex_en_q, ertn_flush_q, flush_q, redirect_valid_q, stall_err_q;
  logic [7:0]  ecode_q, cnt_q, cnt_d;
  logic        esubcode_q;
  logic [31:0] pc_q, vaddr_q, redirect_pc_q;

  logic        take_trap, take_ret, sel_esubcode;
  logic [7:0]  sel_ecode;
  logic [31:0] sel_vaddr;

  excp_prio #(.ECODE_INT(ECODE_INT)) u_prio (
    .wb_valid    (wb_valid),
    .has_int     (has_int),
    .wb_ex       (wb_ex),
    .wb_ertn     (wb_ertn),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_vaddr    (wb_vaddr),
    .take_trap   (take_trap),
    .take_ret    (take_ret),
    .sel_ecode   (sel_ecode),
    .sel_esubcode(sel_esubcode),
    .sel_vaddr   (sel_vaddr)
  );

  assign cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      wb_ready_q       <= 1'b1;
      ex_en_q          <= 1'b0;
      ertn_flush_q     <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      ecode_q          <= 8'h0;
      esubcode_q       <= 1'b0;
      pc_q             <= 32'h0;
      vaddr_q          <= 32'h0;
      cnt_q            <= 8'h0;
      stall_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_trap) begin
            state_q    <= TRAP;
            ex_en_q    <= 1'b1;
            flush_q    <= 1'b1;
            wb_ready_q <= 1'b0;
            ecode_q    <= sel_ecode;
            esubcode_q <= sel_esubcode;
            pc_q       <= wb_pc;
            vaddr_q    <= sel_vaddr;
          end else if (take_ret) begin
            state_q      <= RET;
            ertn_flush_q <= 1'b1;
            flush_q      <= 1'b1;
            wb_ready_q   <= 1'b0;
          end
        end
        // The CSR update lands on this same edge, so the target is sampled before it is visible.
        TRAP: begin
          state_q          <= REDIR;
          ex_en_q          <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= ex_entryPC;
          cnt_q            <= 8'h0;
        end
        RET: begin
          state_q          <= REDIR;
          ertn_flush_q     <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= new_pc;
          cnt_q            <= 8'h0;
        end
        REDIR: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            wb_ready_q       <= 1'b1;
            cnt_q            <= 8'h0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == REDIR_TIMEOUT) stall_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_ready           = wb_ready_q;
  assign ex_en              = ex_en_q;
  assign ertn_flush         = ertn_flush_q;
  assign flush              = flush_q;
  assign redirect_valid     = redirect_valid_q;
  assign redirect_pc        = redirect_pc_q;
  assign ecode              = ecode_q;
  assign esubcode           = esubcode_q;
  assign pc                 = pc_q;
  assign vaddr              = vaddr_q;
  assign redirect_stall_err = stall_err_q;

endmodule
